// File: rtl/async_handshake_sender.sv
// async_handshake_sender: four-phase req/ack initiator with a synchronized ack_in.
// Optional watchdog abort in the wait phases is enabled by defining ASYNC_HANDSHAKE_TIMEOUT_EN.
module async_handshake_sender #(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in
);
    localparam int CW = $clog2(SETUP_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_NACK} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   w_ack_s, w_wd_exp, w_abort;
    assign w_ack_s = r_sync[SYNC_STAGES-1];
`ifdef ASYNC_HANDSHAKE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_wd;
    logic          r_timeout;
    assign w_wd_exp = (r_state == WAIT_ACK || r_state == WAIT_NACK) && r_wd == TW'(TIMEOUT - 1);
    assign timeout  = r_timeout;
    // Watchdog restarts on every state change, so it times each wait phase separately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd      <= (w_next != r_state) ? '0 : r_wd + 1'b1;
            r_timeout <= w_abort;
        end
    end
`else
    assign w_wd_exp = 1'b0;
    assign timeout  = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:      w_next = send ? SETUP : IDLE;
            SETUP:     w_next = (r_cnt <= CW'(1) && !w_ack_s) ? WAIT_ACK : SETUP;
            WAIT_ACK: begin
                w_next  = w_ack_s ? WAIT_NACK : (w_wd_exp ? IDLE : WAIT_ACK);
                w_abort = !w_ack_s && w_wd_exp;
            end
            WAIT_NACK: begin
                w_next  = (!w_ack_s || w_wd_exp) ? IDLE : WAIT_NACK;
                w_abort = w_ack_s && w_wd_exp;
            end
            default:   w_next = IDLE;
        endcase
    end
    // All pad-facing and core-facing outputs come straight from flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            req_out  <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], ack_in};
            r_cnt    <= (r_state == IDLE) ? CW'(SETUP_CYCLES) : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
            req_out  <= w_next == WAIT_ACK;
            data_out <= (r_state == IDLE && send) ? data : data_out;
            busy     <= w_next != IDLE;
            done     <= r_state == WAIT_NACK && w_next == IDLE && !w_abort;
        end
    end
endmodule

// File: doc/async_handshake_sender.md
Name: async_handshake_sender

Overview:
- Four-phase req/ack initiator driving a WIDTH-bit word to an external asynchronous partner, e.g. an off-board capture device or slower FPGA.
- It is the transmit-side counterpart of the team's input synchronizer path. It drives req_out and data_out as glitch-free flop outputs, and samples the partner's asynchronous ack_in through an internal SYNC_STAGES-deep flop chain.
- Sits between core logic (single send/busy/done interface) and the I/O pads.

Parameters:
- WIDTH, 8, data word width.
- SYNC_STAGES, 2, flops in the ack_in synchronizer (minimum 2).
- SETUP_CYCLES, 2, clk cycles data_out is stable before req_out rises (minimum 1).
- TIMEOUT, 255, watchdog limit in clk cycles per wait phase (TIMEOUT_EN builds only).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- send  input  1  start request; sampled on rising clk.
- data  input  WIDTH  word to transmit; captured when send is accepted.
- busy  output  1  high from the acceptance edge until return to IDLE.
- done  output  1  one-cycle pulse on successful handshake completion.
- timeout  output  1  one-cycle pulse on watchdog abort (constant 0 without TIMEOUT_EN).
- req_out  output  1  request to partner; registered.
- data_out  output  WIDTH  data to partner; registered, held from acceptance until the next acceptance.
- ack_in  input  1  partner acknowledge; asynchronous to clk.

Behaviour:
- Reset (async, active-high): state IDLE; req_out=0, data_out=0, busy=0, done=0, timeout=0, sync chain=0, counters=0. Reset mid-transaction aborts immediately with no done/timeout pulse.
- Synchronizer: ack_s is the last stage of the SYNC_STAGES chain. ack_in is never used unsynchronized.
- States: IDLE, SETUP, WAIT_ACK, WAIT_NACK.
- IDLE: on the edge sampling send=1, load data_out<=data, busy<=1, load setup counter with SETUP_CYCLES, go to SETUP.
- send while busy=1 is ignored; the word is not queued.
- SETUP: decrement the counter each cycle. On the edge where the counter has expired and ack_s==0, set req_out<=1 and go to WAIT_ACK.
  - If ack_s is still 1 from a prior aborted transaction, remain in SETUP until it is 0.
  - Example: send sampled at edge E0 with SETUP_CYCLES=2 and ack low gives req_out=1 after edge E2.
- WAIT_ACK: on the edge sampling ack_s==1, set req_out<=0 and go to WAIT_NACK.
- WAIT_NACK: on the edge sampling ack_s==0, go to IDLE with busy<=0 and done<=1 for exactly one cycle.
- data_out never changes while busy=1.
- done and timeout are registered, mutually exclusive, and never asserted in the same cycle as the acceptance of a new send.
- Back-to-back transfers: send may be accepted in the cycle after done is asserted, i.e. when busy=0 and state is IDLE.
- Minimum handshake latency with an immediately-responding partner: SETUP_CYCLES + 2*SYNC_STAGES + 2 cycles from acceptance to done.
- Glitches on ack_in shorter than one clk period may be missed; this is legal, and the partner must hold each ack level until it sees req change.

Optional Feature:
- Macro: ASYNC_HANDSHAKE_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_ACK and to WAIT_NACK, and increments each cycle in those states.
  - When it reaches TIMEOUT: req_out<=0, state IDLE, busy<=0, timeout pulses for one cycle, no done.
  - The next transaction's SETUP phase still waits for ack_s==0.
- Undefined: no watchdog logic; timeout is tied to 0; the FSM waits indefinitely.

Test Plan:
- Nominal: WIDTH=8, SETUP_CYCLES=2. send=1 with data=8'hA5 for one cycle; partner model raises ack 3 cycles after req rises and drops it 3 cycles after req falls -> data_out=A5 throughout, req_out rises 2 cycles after acceptance, exactly one done pulse, busy low after done.
- Busy rejection: during the nominal transfer, pulse send with data=8'h3C -> data_out stays A5, single done, no second req.
- Back-to-back: send A5 then send 5A in the cycle done is high -> the second word is accepted, two complete handshakes, data_out=5A only after the second acceptance.
- Stale ack: force ack_in=1 before send -> req_out stays 0 in SETUP until ack_in has been low for SYNC_STAGES cycles, then the normal handshake completes.
- Reset mid-op: assert reset while in WAIT_ACK with req_out=1 -> req_out, busy and data_out go to 0 asynchronously, no done or timeout; a subsequent send of 8'h11 completes normally.
- Timeout (with ASYNC_HANDSHAKE_TIMEOUT_EN, TIMEOUT=10): partner never acks -> req_out drops 10 cycles after rising, one timeout pulse, no done, busy=0.
